// File: rtl/reqack_sched_pkg.sv
// Shared types and helpers for the req/ack round-robin scheduler.
//   sched_state_t : scheduler FSM states
//   clog2_min1    : index width for a requester count (never below 1 bit)
package reqack_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BUSY  = 2'd2,
        S_ABORT = 2'd3
    } sched_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reqack_sched_if.sv
// Handshake bundle between the scheduler and the single shared resource.
//   req    : scheduler -> resource, request
//   ack    : resource -> scheduler, request accepted
//   done   : resource -> scheduler, transaction finished
//   intrpt : resource -> scheduler, abort current transaction
// master = scheduler side, slave = resource side.
interface reqack_sched_if;
    logic req;
    logic ack;
    logic done;
    logic intrpt;

    modport master (output req, input ack, input done, input intrpt);
    modport slave  (input req, output ack, output done, output intrpt);
endinterface

// File: rtl/reqack_sched_rr_pick.sv
// Combinational round-robin picker.
//   req_vec     : request vector
//   ptr         : index of the last served requester
//   pick_onehot : one-hot winner (zero when nothing requests)
//   pick_idx    : winner index
//   pick_valid  : at least one request present
// The winner is the first set bit searching upward from ptr+1 with wrap.
module rr_pick
    import reqack_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int W     = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [W-1:0]     ptr,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [W-1:0]     pick_idx,
    output logic             pick_valid
);

    logic [W-1:0] cand;

    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        cand       = '0;
        // Scan from the farthest offset to the nearest so that the
        // requester closest after ptr is the last (winning) assignment.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = W'((int'(ptr) + k) % N_REQ);
            if (req_vec[cand]) begin
                pick_idx   = cand;
                pick_valid = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
        assign pick_onehot[gi] = pick_valid && (pick_idx == W'(gi));
    end

endmodule

// File: rtl/reqack_sched.sv
// Round-robin scheduler sharing one req/ack/done/intrpt resource between
// N_REQ requesters, one transaction in flight at a time.
//   clk, reset_n : clock, synchronous active-low reset
//   req_in       : per-requester level request
//   grant_out    : one-hot current owner, zero when idle
//   done_out     : one-cycle completion pulse for the owner
//   abort_out    : one-cycle abort pulse for the owner
//   owner_id     : index of current/last owner
//   proto_err    : sticky protocol-error flag
//   bus          : master side of the shared resource handshake
// Optional: define REQACK_SCHED_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT_CYC cycles (also flags proto_err).
module reqack_sched
    import reqack_sched_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int TIMEOUT_CYC = 64,
    localparam int W           = clog2_min1(N_REQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] grant_out,
    output logic [N_REQ-1:0] done_out,
    output logic [N_REQ-1:0] abort_out,
    output logic [W-1:0]     owner_id,
    output logic             proto_err,
    reqack_sched_if.master   bus
);

    sched_state_t     state_q, state_d;
    logic [W-1:0]     ptr_q, ptr_d;
    logic [W-1:0]     owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] abort_q, abort_d;
    logic             perr_q, perr_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [W-1:0]     pick_idx;
    logic             pick_valid;

`ifdef REQACK_SCHED_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC > 0);
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_vec     (req_in),
        .ptr         (ptr_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= W'(N_REQ - 1);
            owner_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            abort_q <= '0;
            perr_q  <= 1'b0;
`ifdef REQACK_SCHED_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            perr_q  <= perr_d;
`ifdef REQACK_SCHED_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        done_d  = '0;
        abort_d = '0;
        perr_d  = perr_q;
`ifdef REQACK_SCHED_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.ack || bus.done) perr_d = 1'b1;
                if (pick_valid) begin
                    state_d = S_REQ;
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
`ifdef REQACK_SCHED_TIMEOUT_EN
                    tmo_d   = TMO_LOAD;
`endif
                end
            end
            S_REQ: begin
                if (bus.done) perr_d = 1'b1;
                // intrpt outranks ack; grant_q already holds the owner one-hot
                if (bus.intrpt) begin
                    state_d = S_ABORT;
                    grant_d = '0;
                    abort_d = grant_q;
                    ptr_d   = owner_q;
                end else if (bus.ack) begin
                    state_d = S_BUSY;
`ifdef REQACK_SCHED_TIMEOUT_EN
                end else if (tmo_q == '0) begin
                    state_d = S_ABORT;
                    grant_d = '0;
                    abort_d = grant_q;
                    ptr_d   = owner_q;
                    perr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q - TW'(1);
`endif
                end
            end
            S_BUSY: begin
                if (bus.ack) perr_d = 1'b1;
                if (bus.intrpt) begin
                    state_d = S_ABORT;
                    grant_d = '0;
                    abort_d = grant_q;
                    ptr_d   = owner_q;
                end else if (bus.done) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    done_d  = grant_q;
                    ptr_d   = owner_q;
                end
            end
            S_ABORT: begin
                // One dead cycle keeps the next grant off the abort pulse.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        grant_out = grant_q;
        done_out  = done_q;
        abort_out = abort_q;
        owner_id  = owner_q;
        proto_err = perr_q;
    end

    assign bus.req = (state_q == S_REQ);

endmodule
